// File: rtl/crypto_frame_sequencer_pkg.sv
// Shared types and constants for the crypto frame sequencer.
package crypto_pkg;

  localparam int BYTE_W = 8;

  localparam logic [BYTE_W-1:0] CMD_ENC_DEF = 8'h45;
  localparam logic [BYTE_W-1:0] CMD_DEC_DEF = 8'h44;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_GET_KEY  = 3'd1;
  localparam logic [2:0] ST_GET_DATA = 3'd2;
  localparam logic [2:0] ST_COMPUTE  = 3'd3;
  localparam logic [2:0] ST_SEND     = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE     = ST_IDLE,
    S_GET_KEY  = ST_GET_KEY,
    S_GET_DATA = ST_GET_DATA,
    S_COMPUTE  = ST_COMPUTE,
    S_SEND     = ST_SEND
  } seq_state_t;

  // The idle timeout only runs while a frame is partially received.
  function automatic logic waits_for_byte(seq_state_t s);
    return (s == S_GET_KEY) || (s == S_GET_DATA);
  endfunction

endpackage

// File: rtl/crypto_frame_sequencer_if.sv
// Byte-stream, cipher and result-sink signals bundled for the sequencer.
interface crypto_frame_sequencer_if;
  import crypto_pkg::*;

  logic              rx_valid;
  logic [BYTE_W-1:0] rx_data;

  logic              cph_sel;
  logic [BYTE_W-1:0] cph_in;
  logic [BYTE_W-1:0] cph_key;
  logic [BYTE_W-1:0] cph_out;

  logic              tx_valid;
  logic [BYTE_W-1:0] tx_data;
  logic              tx_ready;

  // Sequencer side
  modport master (
    input  rx_valid, rx_data, cph_out, tx_ready,
    output cph_sel, cph_in, cph_key, tx_valid, tx_data
  );

  // Environment side: byte source, cipher core and byte sink
  modport slave (
    output rx_valid, rx_data, cph_out, tx_ready,
    input  cph_sel, cph_in, cph_key, tx_valid, tx_data
  );

endinterface

// File: rtl/crypto_frame_sequencer_timeout_ctr.sv
// Clear/enable counter that flags when LIMIT consecutive enabled cycles
// have elapsed since the last clear. Holds at the terminal value.
module seq_timeout_ctr #(
  parameter int          WIDTH = 16,
  parameter int unsigned LIMIT = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] count;

  assign expired = (count == LAST);

  // Count enabled cycles since the last clear, saturating at LAST.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/crypto_frame_sequencer.sv
// Collects command/key/data frames from a byte stream, drives the cipher
// core, and hands the result byte to a valid/ready sink.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for a command byte (ENC/DEC), others flag err_cmd
// GET_KEY  | waiting for key byte, idle timeout running
// GET_DATA | waiting for data byte, idle timeout running
// COMPUTE  | cipher inputs stable, latency counter running down
// SEND     | result held on tx_* until the sink accepts it
module crypto_frame_sequencer
  import crypto_pkg::*;
#(
  parameter logic [BYTE_W-1:0] CMD_ENC    = CMD_ENC_DEF,
  parameter logic [BYTE_W-1:0] CMD_DEC    = CMD_DEC_DEF,
  parameter int unsigned       CIPHER_LAT = 1,
  parameter int unsigned       TIMEOUT    = 1000
) (
  input  logic                     clk,
  input  logic                     rst,
  crypto_frame_sequencer_if.master bus,
  output logic                     busy,
  output logic                     err_cmd,
  output logic                     err_timeout,
  output logic                     err_overrun,
  output logic [BYTE_W-1:0]        frame_cnt
);

  localparam logic [3:0] LAT_LOAD = 4'(CIPHER_LAT);

  seq_state_t state, state_d;

  logic              sel_q, sel_d;
  logic [BYTE_W-1:0] key_q, key_d;
  logic [BYTE_W-1:0] in_q, in_d;
  logic              txv_q, txv_d;
  logic [BYTE_W-1:0] txd_q, txd_d;
  logic [BYTE_W-1:0] cnt_q, cnt_d;
  logic [3:0]        lat_q, lat_d;
  logic              err_cmd_q, err_cmd_d;
  logic              err_to_q, err_to_d;
  logic              err_ov_q, err_ov_d;

  logic to_clear;
  logic to_expired;

  // Idle counter restarts outside the receive states and on every byte.
  assign to_clear = !waits_for_byte(state) || bus.rx_valid;

  seq_timeout_ctr #(
    .WIDTH (16),
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (to_clear),
    .enable  (1'b1),
    .expired (to_expired)
  );

  assign bus.cph_sel  = sel_q;
  assign bus.cph_key  = key_q;
  assign bus.cph_in   = in_q;
  assign bus.tx_valid = txv_q;
  assign bus.tx_data  = txd_q;

  assign busy        = (state != S_IDLE);
  assign err_cmd     = err_cmd_q;
  assign err_timeout = err_to_q;
  assign err_overrun = err_ov_q;
  assign frame_cnt   = cnt_q;

  // Next-state and next-register values; error pulses default low.
  always_comb begin
    state_d   = state;
    sel_d     = sel_q;
    key_d     = key_q;
    in_d      = in_q;
    txv_d     = txv_q;
    txd_d     = txd_q;
    cnt_d     = cnt_q;
    lat_d     = lat_q;
    err_cmd_d = 1'b0;
    err_to_d  = 1'b0;
    err_ov_d  = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == CMD_ENC) begin
            sel_d   = 1'b1;
            state_d = S_GET_KEY;
          end else if (bus.rx_data == CMD_DEC) begin
            sel_d   = 1'b0;
            state_d = S_GET_KEY;
          end else begin
            err_cmd_d = 1'b1;
          end
        end
      end

      S_GET_KEY: begin
        // A byte on the expiry cycle still counts; it is checked first.
        if (bus.rx_valid) begin
          key_d   = bus.rx_data;
          state_d = S_GET_DATA;
        end else if (to_expired) begin
          err_to_d = 1'b1;
          state_d  = S_IDLE;
        end
      end

      S_GET_DATA: begin
        if (bus.rx_valid) begin
          in_d    = bus.rx_data;
          lat_d   = LAT_LOAD;
          state_d = S_COMPUTE;
        end else if (to_expired) begin
          err_to_d = 1'b1;
          state_d  = S_IDLE;
        end
      end

      S_COMPUTE: begin
        if (bus.rx_valid) begin
          err_ov_d = 1'b1;
        end
        if (lat_q == 4'd0) begin
          txd_d   = bus.cph_out;
          txv_d   = 1'b1;
          state_d = S_SEND;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end

      S_SEND: begin
        if (bus.rx_valid) begin
          err_ov_d = 1'b1;
        end
        if (txv_q && bus.tx_ready) begin
          txv_d   = 1'b0;
          cnt_d   = cnt_q + 8'd1;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Datapath, counters and registered error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q     <= 1'b0;
      key_q     <= '0;
      in_q      <= '0;
      txv_q     <= 1'b0;
      txd_q     <= '0;
      cnt_q     <= '0;
      lat_q     <= '0;
      err_cmd_q <= 1'b0;
      err_to_q  <= 1'b0;
      err_ov_q  <= 1'b0;
    end else begin
      sel_q     <= sel_d;
      key_q     <= key_d;
      in_q      <= in_d;
      txv_q     <= txv_d;
      txd_q     <= txd_d;
      cnt_q     <= cnt_d;
      lat_q     <= lat_d;
      err_cmd_q <= err_cmd_d;
      err_to_q  <= err_to_d;
      err_ov_q  <= err_ov_d;
    end
  end

endmodule

// File: tb/tb_crypto_frame_sequencer.sv
// Self-checking bench for crypto_frame_sequencer with an XOR cipher stub.
module tb_crypto_frame_sequencer;
  import crypto_pkg::*;

  localparam int         LAT = 1;
  localparam int         TMO = 1000;
  localparam logic [7:0] ENC = 8'h45;
  localparam logic [7:0] DEC = 8'h44;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy, err_cmd, err_timeout, err_overrun;
  logic [7:0] frame_cnt;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;

  crypto_frame_sequencer_if bus ();

  crypto_frame_sequencer #(
    .CMD_ENC    (ENC),
    .CMD_DEC    (DEC),
    .CIPHER_LAT (LAT),
    .TIMEOUT    (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .busy        (busy),
    .err_cmd     (err_cmd),
    .err_timeout (err_timeout),
    .err_overrun (err_overrun),
    .frame_cnt   (frame_cnt)
  );

  // Cipher stub
  assign bus.cph_out = bus.cph_in ^ bus.cph_key;

  always #5 clk = ~clk;

  // Reference: result of a frame is data XOR key; latency is LAT+1 edges.
  function automatic logic [7:0] model_result(logic [7:0] k, logic [7:0] d);
    return d ^ k;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_tx(output int n);
    n = 0;
    while (bus.tx_valid !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({busy, err_cmd, err_timeout, err_overrun, bus.tx_valid, bus.cph_sel} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b required 000000", {busy, err_cmd, err_timeout, err_overrun, bus.tx_valid, bus.cph_sel});
    end
    checks++;
    if ({bus.tx_data, bus.cph_in, bus.cph_key, frame_cnt} !== 32'h0) begin
      failures++;
      $display("FAIL reset_bytes: got %h required 00000000", {bus.tx_data, bus.cph_in, bus.cph_key, frame_cnt});
    end
    rst = 1'b0;
    exp_cnt = 0;
    tick();
  endtask

  task automatic test_encrypt();
    int n;
    strobe(ENC);
    checks++;
    if (busy !== 1'b1 || bus.cph_sel !== 1'b1) begin
      failures++;
      $display("FAIL enc_sel: busy=%b sel=%b required 1 1", busy, bus.cph_sel);
    end
    strobe(8'h18);
    checks++;
    if (bus.cph_key !== 8'h18) begin
      failures++;
      $display("FAIL enc_key: got %h required 18", bus.cph_key);
    end
    strobe(8'h84);
    checks++;
    if (bus.cph_in !== 8'h84) begin
      failures++;
      $display("FAIL enc_in: got %h required 84", bus.cph_in);
    end
    wait_tx(n);
    checks++;
    if (n !== LAT + 1) begin
      failures++;
      $display("FAIL enc_latency: got %0d required %0d", n, LAT + 1);
    end
    checks++;
    if (bus.tx_data !== 8'h9C) begin
      failures++;
      $display("FAIL enc_result: got %h required 9c", bus.tx_data);
    end
    tick();
    exp_cnt++;
    checks++;
    if (bus.tx_valid !== 1'b0 || busy !== 1'b0 || frame_cnt !== 8'(exp_cnt)) begin
      failures++;
      $display("FAIL enc_done: txv=%b busy=%b cnt=%0d required 0 0 %0d", bus.tx_valid, busy, frame_cnt, exp_cnt);
    end
  endtask

  task automatic test_decrypt_backpressure();
    int n;
    bus.tx_ready = 1'b0;
    strobe(DEC);
    checks++;
    if (bus.cph_sel !== 1'b0) begin
      failures++;
      $display("FAIL dec_sel: got %b required 0", bus.cph_sel);
    end
    strobe(8'h18);
    strobe(8'hD2);
    wait_tx(n);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hCA || busy !== 1'b1) begin
        failures++;
        $display("FAIL dec_hold%0d: txv=%b data=%h busy=%b required 1 ca 1", i, bus.tx_valid, bus.tx_data, busy);
      end
      if (i < 4) tick();
    end
    bus.tx_ready = 1'b1;
    tick();
    exp_cnt++;
    checks++;
    if (bus.tx_valid !== 1'b0 || busy !== 1'b0 || frame_cnt !== 8'(exp_cnt)) begin
      failures++;
      $display("FAIL dec_accept: txv=%b busy=%b cnt=%0d required 0 0 %0d", bus.tx_valid, busy, frame_cnt, exp_cnt);
    end
  endtask

  task automatic test_bad_command();
    int n;
    strobe(8'h41);
    checks++;
    if (err_cmd !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL badcmd_pulse: err=%b busy=%b required 1 0", err_cmd, busy);
    end
    tick();
    checks++;
    if (err_cmd !== 1'b0) begin
      failures++;
      $display("FAIL badcmd_width: got %b required 0", err_cmd);
    end
    strobe(ENC);
    strobe(8'h01);
    strobe(8'h02);
    wait_tx(n);
    checks++;
    if (bus.tx_data !== model_result(8'h01, 8'h02) || n !== LAT + 1) begin
      failures++;
      $display("FAIL badcmd_next: data=%h lat=%0d required %h %0d", bus.tx_data, n, model_result(8'h01, 8'h02), LAT + 1);
    end
    tick();
    exp_cnt++;
  endtask

  task automatic test_timeout();
    int n;
    strobe(ENC);
    strobe(8'h18);
    n = 0;
    while (err_timeout !== 1'b1 && n < TMO + 20) begin
      tick();
      n++;
    end
    checks++;
    if (n !== TMO || busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_fire: cycles=%0d busy=%b required %0d 0", n, busy, TMO);
    end
    tick();
    checks++;
    if (err_timeout !== 1'b0) begin
      failures++;
      $display("FAIL timeout_width: got %b required 0", err_timeout);
    end
    strobe(8'h84);
    checks++;
    if (err_cmd !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_after: err_cmd=%b busy=%b required 1 0", err_cmd, busy);
    end
    tick();
  endtask

  task automatic test_timeout_boundary();
    int n;
    strobe(DEC);
    for (int i = 0; i < TMO - 1; i++) tick();
    strobe(8'h3A);
    checks++;
    if (busy !== 1'b1 || err_timeout !== 1'b0 || bus.cph_key !== 8'h3A) begin
      failures++;
      $display("FAIL tmo_edge: busy=%b err=%b key=%h required 1 0 3a", busy, err_timeout, bus.cph_key);
    end
    strobe(8'hC5);
    wait_tx(n);
    checks++;
    if (bus.tx_data !== model_result(8'h3A, 8'hC5)) begin
      failures++;
      $display("FAIL tmo_edge_result: got %h required %h", bus.tx_data, model_result(8'h3A, 8'hC5));
    end
    tick();
    exp_cnt++;
  endtask

  task automatic test_overrun();
    int n;
    bus.tx_ready = 1'b0;
    strobe(ENC);
    strobe(8'h5A);
    strobe(8'h3C);
    strobe(8'hFF);
    checks++;
    if (err_overrun !== 1'b1 || bus.tx_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL ovr_compute: err=%b txv=%b busy=%b required 1 0 1", err_overrun, bus.tx_valid, busy);
    end
    wait_tx(n);
    checks++;
    if (bus.tx_data !== model_result(8'h5A, 8'h3C)) begin
      failures++;
      $display("FAIL ovr_result: got %h required %h", bus.tx_data, model_result(8'h5A, 8'h3C));
    end
    strobe(8'h77);
    checks++;
    if (err_overrun !== 1'b1 || bus.tx_valid !== 1'b1 || bus.tx_data !== model_result(8'h5A, 8'h3C)) begin
      failures++;
      $display("FAIL ovr_send: err=%b txv=%b data=%h required 1 1 %h", err_overrun, bus.tx_valid, bus.tx_data, model_result(8'h5A, 8'h3C));
    end
    tick();
    checks++;
    if (err_overrun !== 1'b0 || bus.cph_in !== 8'h3C) begin
      failures++;
      $display("FAIL ovr_width: err=%b in=%h required 0 3c", err_overrun, bus.cph_in);
    end
    bus.tx_ready = 1'b1;
    tick();
    exp_cnt++;
    checks++;
    if (frame_cnt !== 8'(exp_cnt) || busy !== 1'b0) begin
      failures++;
      $display("FAIL ovr_done: cnt=%0d busy=%b required %0d 0", frame_cnt, busy, exp_cnt);
    end
  endtask

  task automatic test_reset_midframe();
    strobe(ENC);
    strobe(8'hAA);
    rst = 1'b1;
    tick();
    exp_cnt = 0;
    checks++;
    if ({busy, bus.cph_sel, bus.tx_valid, err_cmd, err_timeout, err_overrun} !== 6'b0 ||
        {bus.cph_key, bus.cph_in, bus.tx_data, frame_cnt} !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid: flags=%b bytes=%h required 000000 00000000", {busy, bus.cph_sel, bus.tx_valid, err_cmd, err_timeout, err_overrun}, {bus.cph_key, bus.cph_in, bus.tx_data, frame_cnt});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [7:0] cmd, k, d, want;
      int r, stall, n;
      r = $urandom_range(0, 9);
      if (r < 4) cmd = ENC;
      else if (r < 8) cmd = DEC;
      else begin
        cmd = 8'($urandom);
        if (cmd == ENC || cmd == DEC) cmd = 8'h00;
      end
      k = 8'($urandom);
      d = 8'($urandom);
      want = model_result(k, d);
      stall = $urandom_range(0, 3);
      strobe(cmd);
      if (cmd != ENC && cmd != DEC) begin
        checks++;
        if (err_cmd !== 1'b1 || busy !== 1'b0) begin
          failures++;
          $display("FAIL rnd%0d_badcmd: err=%b busy=%b required 1 0", i, err_cmd, busy);
        end
        tick();
        continue;
      end
      checks++;
      if (bus.cph_sel !== (cmd == ENC)) begin
        failures++;
        $display("FAIL rnd%0d_sel: got %b required %b", i, bus.cph_sel, cmd == ENC);
      end
      repeat ($urandom_range(0, 3)) tick();
      strobe(k);
      repeat ($urandom_range(0, 3)) tick();
      if (stall > 0) bus.tx_ready = 1'b0;
      strobe(d);
      wait_tx(n);
      checks++;
      if (n !== LAT + 1 || bus.tx_data !== want) begin
        failures++;
        $display("FAIL rnd%0d_result: lat=%0d data=%h required %0d %h", i, n, bus.tx_data, LAT + 1, want);
      end
      for (int j = 0; j < stall; j++) begin
        tick();
        checks++;
        if (bus.tx_valid !== 1'b1 || bus.tx_data !== want) begin
          failures++;
          $display("FAIL rnd%0d_hold: txv=%b data=%h required 1 %h", i, bus.tx_valid, bus.tx_data, want);
        end
      end
      bus.tx_ready = 1'b1;
      tick();
      exp_cnt++;
      checks++;
      if (frame_cnt !== 8'(exp_cnt) || bus.tx_valid !== 1'b0) begin
        failures++;
        $display("FAIL rnd%0d_cnt: cnt=%0d txv=%b required %0d 0", i, frame_cnt, bus.tx_valid, exp_cnt);
      end
    end
  endtask

  task automatic test_back_to_back();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] k, d;
      int n;
      k = 8'($urandom);
      d = 8'($urandom);
      strobe((i % 2 == 0) ? ENC : DEC);
      strobe(k);
      strobe(d);
      wait_tx(n);
      checks++;
      if (bus.tx_data !== model_result(k, d)) begin
        failures++;
        $display("FAIL b2b%0d_result: got %h required %h", i, bus.tx_data, model_result(k, d));
      end
      tick();
      exp_cnt++;
    end
    checks++;
    if (frame_cnt !== 8'(exp_cnt) || frame_cnt !== 8'h00) begin
      failures++;
      $display("FAIL wrap_cnt: got %h required 00", frame_cnt);
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_ready = 1'b1;
    test_reset();
    test_encrypt();
    test_decrypt_backpressure();
    test_bad_command();
    test_timeout();
    test_timeout_boundary();
    test_overrun();
    test_reset_midframe();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
